// File: rtl/regfile_write_sequencer.sv
// Write front-end for the register file: queues write requests, filters out-of-range
// addresses and sequences hardware range-fill commands onto the single write port.
module regfile_write_sequencer #(
  parameter int addr_width = 1,
  parameter int data_width = 1,
  parameter int lo         = 0,
  parameter int hi         = 1,
  parameter int depth      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [addr_width-1:0] REQ_ADDR,
  input  logic [data_width-1:0] REQ_DATA,
  input  logic                  REQ_VALID,
  output logic                  REQ_RDY,
  input  logic                  FILL_START,
  input  logic [addr_width-1:0] FILL_LO,
  input  logic [addr_width-1:0] FILL_HI,
  input  logic [data_width-1:0] FILL_DATA,
  output logic                  FILL_BUSY,
  output logic                  FILL_DONE,
  output logic                  ERR,
  output logic [7:0]            ERR_CNT,
  output logic [addr_width-1:0] ADDR_IN,
  output logic [data_width-1:0] D_IN,
  output logic                  WE
);
  localparam int          PW       = $clog2(depth);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(depth);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FILL} state_t;
  state_t state_q, state_d;

  logic [addr_width-1:0] fifo_addr_q [depth];
  logic [data_width-1:0] fifo_data_q [depth];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;

  logic [addr_width-1:0] fill_lo_q, fill_lo_d, fill_hi_q, fill_hi_d, fill_cnt_q, fill_cnt_d;
  logic [data_width-1:0] fill_data_q, fill_data_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [data_width-1:0] din_q, din_d;
  logic                  we_q, we_d, done_q, done_d, err_q, err_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic req_fire, req_ok, fill_cmd, fill_ok, fill_last, push, pop, bypass;

  function automatic logic in_range(input logic [addr_width-1:0] a);
    return (int'(a) >= lo) && (int'(a) <= hi);
  endfunction

  assign req_fire  = REQ_VALID && REQ_RDY;
  assign req_ok    = req_fire && in_range(REQ_ADDR);
  assign fill_cmd  = FILL_START && (state_q == S_IDLE);
  assign fill_ok   = fill_cmd && in_range(FILL_LO) && in_range(FILL_HI) && (FILL_LO <= FILL_HI);
  assign fill_last = (fill_cnt_q == fill_hi_q);
  assign pop       = (state_q != S_FILL) && (count_q != '0);
  assign push      = req_ok && (count_q != '0);
  assign bypass    = req_ok && (count_q == '0);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (fill_ok)        state_d = S_DRAIN;
      S_DRAIN: if (count_q == '0)  state_d = S_FILL;
      S_FILL:  if (fill_last)      state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    REQ_RDY   = !RST && (state_q == S_IDLE) && (count_q < FULL_CNT);
    FILL_BUSY = (state_q != S_IDLE);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    fill_lo_d   = fill_lo_q;
    fill_hi_d   = fill_hi_q;
    fill_data_d = fill_data_q;
    fill_cnt_d  = fill_cnt_q;
    addr_d      = addr_q;
    din_d       = din_q;
    we_d        = 1'b0;
    done_d      = (state_q == S_FILL) && fill_last;
    err_d       = (req_fire && !in_range(REQ_ADDR)) || (fill_cmd && !fill_ok);
    err_cnt_d   = (err_d && (err_cnt_q != '1)) ? err_cnt_q + 8'd1 : err_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    if (fill_ok) begin
      fill_lo_d   = FILL_LO;
      fill_hi_d   = FILL_HI;
      fill_data_d = FILL_DATA;
    end

    // Output register is loaded one cycle ahead: an empty FIFO passes the request
    // straight through, and the last DRAIN cycle already issues the first fill write.
    if (pop) begin
      we_d   = 1'b1;
      addr_d = fifo_addr_q[rd_ptr_q];
      din_d  = fifo_data_q[rd_ptr_q];
    end else if (bypass) begin
      we_d   = 1'b1;
      addr_d = REQ_ADDR;
      din_d  = REQ_DATA;
    end else if (state_q == S_DRAIN) begin
      we_d       = 1'b1;
      addr_d     = fill_lo_q;
      din_d      = fill_data_q;
      fill_cnt_d = fill_lo_q;
    end else if ((state_q == S_FILL) && !fill_last) begin
      we_d       = 1'b1;
      addr_d     = fill_cnt_q + 1'b1;
      din_d      = fill_data_q;
      fill_cnt_d = fill_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= REQ_ADDR;
      fifo_data_q[wr_ptr_q] <= REQ_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fill_lo_q   <= '0;
      fill_hi_q   <= '0;
      fill_data_q <= '0;
      fill_cnt_q  <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fill_lo_q   <= fill_lo_d;
      fill_hi_q   <= fill_hi_d;
      fill_data_q <= fill_data_d;
      fill_cnt_q  <= fill_cnt_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      we_q        <= we_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign ADDR_IN   = addr_q;
  assign D_IN      = din_q;
  assign WE        = we_q;
  assign FILL_DONE = done_q;
  assign ERR       = err_q;
  assign ERR_CNT   = err_cnt_q;

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Bench for regfile_write_sequencer: cycle-scheduled reference model on one instance,
// plus a full-width instance (hi = 2^addr_width-1) for the fill-termination edge.
module tb_regfile_write_sequencer;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int LO = 2;
  localparam int HI = 20;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [AW-1:0] a_addr, a_flo, a_fhi, a_addr_in;
  logic [DW-1:0] a_data, a_fd, a_din;
  logic          a_valid, a_rdy, a_fs, a_busy, a_done, a_err, a_we;
  logic [7:0]    a_errcnt;

  logic [3:0]    b_addr, b_flo, b_fhi, b_addr_in;
  logic [DW-1:0] b_data, b_fd, b_din;
  logic          b_valid, b_rdy, b_fs, b_busy, b_done, b_err, b_we;
  logic [7:0]    b_errcnt;

  regfile_write_sequencer #(
    .addr_width(AW), .data_width(DW), .lo(LO), .hi(HI), .depth(4)
  ) u_dut (
    .CLK(CLK), .RST(RST),
    .REQ_ADDR(a_addr), .REQ_DATA(a_data), .REQ_VALID(a_valid), .REQ_RDY(a_rdy),
    .FILL_START(a_fs), .FILL_LO(a_flo), .FILL_HI(a_fhi), .FILL_DATA(a_fd),
    .FILL_BUSY(a_busy), .FILL_DONE(a_done), .ERR(a_err), .ERR_CNT(a_errcnt),
    .ADDR_IN(a_addr_in), .D_IN(a_din), .WE(a_we)
  );

  regfile_write_sequencer #(
    .addr_width(4), .data_width(DW), .lo(0), .hi(15), .depth(4)
  ) u_wrap (
    .CLK(CLK), .RST(RST),
    .REQ_ADDR(b_addr), .REQ_DATA(b_data), .REQ_VALID(b_valid), .REQ_RDY(b_rdy),
    .FILL_START(b_fs), .FILL_LO(b_flo), .FILL_HI(b_fhi), .FILL_DATA(b_fd),
    .FILL_BUSY(b_busy), .FILL_DONE(b_done), .ERR(b_err), .ERR_CNT(b_errcnt),
    .ADDR_IN(b_addr_in), .D_IN(b_din), .WE(b_we)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  // Reference model: expected events keyed by absolute cycle number.
  logic [AW+DW-1:0] exp_wr [int];
  bit               exp_err [int];
  bit               exp_done [int];
  int busy_start = 1;
  int busy_end   = 0;
  int model_cnt  = 0;

  function automatic bit a_in_range(input int a);
    return (a >= LO) && (a <= HI);
  endfunction

  task automatic step(input bit v, input int ad, input int dt,
                      input bit fs, input int flo, input int fhi, input int fd);
    bit idle;
    int c;
    logic [AW+DW-1:0] w;
    a_valid = v;  a_addr = AW'(ad);  a_data = DW'(dt);
    a_fs = fs;    a_flo = AW'(flo);  a_fhi = AW'(fhi);  a_fd = DW'(fd);
    @(negedge CLK);
    c = cyc;
    idle = !((c >= busy_start) && (c <= busy_end));
    if (exp_err.exists(c) && (model_cnt < 255)) model_cnt++;
    check("REQ_RDY", 32'(a_rdy), 32'(idle));
    check("FILL_BUSY", 32'(a_busy), 32'(!idle));
    check("WE", 32'(a_we), 32'(exp_wr.exists(c)));
    if (exp_wr.exists(c)) begin
      w = exp_wr[c];
      check("ADDR_IN", 32'(a_addr_in), 32'(w[AW+DW-1:DW]));
      check("D_IN", 32'(a_din), 32'(w[DW-1:0]));
    end
    check("ERR", 32'(a_err), 32'(exp_err.exists(c)));
    check("ERR_CNT", 32'(a_errcnt), 32'(model_cnt));
    check("FILL_DONE", 32'(a_done), 32'(exp_done.exists(c)));
    if (v && idle) begin
      if (a_in_range(ad)) exp_wr[c+1] = {AW'(ad), DW'(dt)};
      else                exp_err[c+1] = 1'b1;
    end
    if (fs && idle) begin
      if (a_in_range(flo) && a_in_range(fhi) && (flo <= fhi)) begin
        busy_start = c + 1;
        busy_end   = c + 2 + (fhi - flo);
        for (int i = 0; i <= fhi - flo; i++) exp_wr[c+2+i] = {AW'(flo + i), DW'(fd)};
        exp_done[busy_end+1] = 1'b1;
      end else begin
        exp_err[c+1] = 1'b1;
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic idle_step();
    step(1'b0, 0, 0, 1'b0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1; a_valid = 1'b0; a_fs = 1'b0; b_fs = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check("REQ_RDY in reset", 32'(a_rdy), 32'd0);
      @(posedge CLK); #1;
    end
    RST = 1'b0;
    exp_wr.delete(); exp_err.delete(); exp_done.delete();
    busy_start = 1; busy_end = 0; model_cnt = 0;
  endtask

  task automatic b_fill(input int flo, input int fhi, input int fd);
    int c0, nd, done_cyc;
    int wc[$];
    logic [3:0] wa[$];
    logic [DW-1:0] wd[$];
    nd = 0; done_cyc = -1;
    b_fs = 1'b1; b_flo = 4'(flo); b_fhi = 4'(fhi); b_fd = DW'(fd);
    c0 = cyc;
    @(posedge CLK); #1;
    b_fs = 1'b0;
    for (int k = 0; k < fhi - flo + 8; k++) begin
      @(negedge CLK);
      if (b_we) begin wc.push_back(cyc); wa.push_back(b_addr_in); wd.push_back(b_din); end
      if (b_done) begin nd++; done_cyc = cyc; end
    end
    @(posedge CLK); #1;
    check("wrap write count", 32'(wc.size()), 32'(fhi - flo + 1));
    for (int i = 0; i < wc.size(); i++) begin
      check("wrap write cycle", 32'(wc[i]), 32'(c0 + 2 + i));
      check("wrap write addr", 32'(wa[i]), 32'(flo + i));
      check("wrap write data", 32'(wd[i]), 32'(fd));
    end
    check("wrap FILL_DONE count", 32'(nd), 32'd1);
    check("wrap FILL_DONE cycle", 32'(done_cyc), 32'(c0 + 3 + fhi - flo));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    a_valid = 1'b0; a_addr = '0; a_data = '0; a_fs = 1'b0; a_flo = '0; a_fhi = '0; a_fd = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0; b_fs = 1'b0; b_flo = '0; b_fhi = '0; b_fd = '0;
    #1;
    do_reset(2);

    @(negedge CLK);
    check("reset WE", 32'(a_we), 32'd0);
    check("reset ADDR_IN", 32'(a_addr_in), 32'd0);
    check("reset D_IN", 32'(a_din), 32'd0);
    check("reset FILL_BUSY", 32'(a_busy), 32'd0);
    check("reset FILL_DONE", 32'(a_done), 32'd0);
    check("reset ERR", 32'(a_err), 32'd0);
    check("reset ERR_CNT", 32'(a_errcnt), 32'd0);
    check("reset REQ_RDY", 32'(a_rdy), 32'd1);
    check("wrap reset WE", 32'(b_we), 32'd0);
    check("wrap reset REQ_RDY", 32'(b_rdy), 32'd1);
    check("wrap reset FILL_BUSY", 32'(b_busy), 32'd0);
    @(posedge CLK); #1;

    // Full-width instance: fills ending at the top address must stop there.
    b_fill(14, 15, 'h3C);
    b_fill(0, 15, 'hA5);
    b_fill(15, 15, 'h81);
    check("wrap ERR_CNT", 32'(b_errcnt), 32'd0);
    check("wrap ERR", 32'(b_err), 32'd0);

    for (int k = 0; k < 8; k++) step(1'b1, k + 2, 'hA0 + k, 1'b0, 0, 0, 0);
    repeat (2) idle_step();

    step(1'b1, 25, 'h11, 1'b0, 0, 0, 0);
    idle_step();
    step(1'b1, 1, 'h12, 1'b0, 0, 0, 0);
    step(1'b1, HI, 'h13, 1'b0, 0, 0, 0);
    step(1'b1, LO, 'h14, 1'b0, 0, 0, 0);
    step(1'b1, HI + 1, 'h15, 1'b0, 0, 0, 0);
    repeat (2) idle_step();

    step(1'b1, 3, 'h31, 1'b0, 0, 0, 0);
    step(1'b1, 7, 'h32, 1'b0, 0, 0, 0);
    step(1'b1, 9, 'h33, 1'b0, 0, 0, 0);
    step(1'b1, 4, 'h34, 1'b1, 2, 5, 'h55);
    step(1'b1, 6, 'h77, 1'b1, 3, 4, 'h99);
    step(1'b1, 8, 'h78, 1'b0, 0, 0, 0);
    repeat (6) idle_step();

    step(1'b0, 0, 0, 1'b1, 6, 3, 'hEE);
    idle_step();
    step(1'b0, 0, 0, 1'b1, 1, 4, 'hEE);
    step(1'b0, 0, 0, 1'b1, 5, 25, 'hEE);
    step(1'b1, 30, 'h01, 1'b1, 7, 2, 'hEE);
    repeat (2) idle_step();

    step(1'b0, 0, 0, 1'b1, 10, 10, 'hC3);
    repeat (4) idle_step();
    step(1'b0, 0, 0, 1'b1, LO, HI, 'h6B);
    repeat (24) idle_step();

    repeat (400) begin
      bit fs;
      int flo, fhi;
      fs = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 1) begin
        flo = $urandom_range(LO, HI);
        fhi = $urandom_range(flo, HI);
      end else begin
        flo = $urandom_range(0, 31);
        fhi = $urandom_range(0, 31);
      end
      step($urandom_range(0, 9) < 6, $urandom_range(0, 31), $urandom_range(0, 255),
           fs, flo, fhi, $urandom_range(0, 255));
    end
    repeat (25) idle_step();

    step(1'b0, 0, 0, 1'b1, LO, HI, 'h5A);
    repeat (6) idle_step();
    do_reset(1);
    repeat (30) idle_step();

    repeat (300) begin
      int r;
      r = $urandom_range(0, 12);
      step(1'b1, (r < 2) ? r : r + 19, $urandom_range(0, 255), 1'b0, 0, 0, 0);
    end
    repeat (2) idle_step();
    check("ERR_CNT saturated", 32'(a_errcnt), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
